// File: rtl/canvas_painter.sv
// ============================================================================
// Module      : canvas_painter
// Description : Turns cursor/paint commands into frame-buffer cell writes
//               (brush stamp or full-canvas clear) and tracks the pen position.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module canvas_painter #(
    parameter int CANVAS_W   = 160,
    parameter int CANVAS_H   = 120,
    parameter int SCALE_LOG2 = 2,
    parameter int BRUSH      = 3,
    parameter int ADDR_W     = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [9:0]        cmd_x,
    input  logic [9:0]        cmd_y,
    input  logic [2:0]        cmd_color,
    input  logic              cmd_clear,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [2:0]        wr_color,
    output logic [9:0]        pen_x,
    output logic [9:0]        pen_y,
    output logic              busy
);

    localparam int                  c_cells      = CANVAS_W * CANVAS_H;
    localparam logic [ADDR_W-1:0]   c_last_addr  = ADDR_W'(c_cells - 1);
    localparam logic [2:0]          c_brush_last = 3'(BRUSH - 1);
    localparam logic signed [11:0]  c_half       = 12'(BRUSH / 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PAINT = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [9:0]         r_ccx;
    logic [9:0]         r_ccy;
    logic [2:0]         r_color;
    logic [2:0]         r_dx;
    logic [2:0]         r_dy;
    logic [ADDR_W-1:0]  r_clr_addr;
    logic [9:0]         r_pen_x;
    logic [9:0]         r_pen_y;

    logic               w_accept;
    logic               w_last_offset;
    logic signed [11:0] w_cx;
    logic signed [11:0] w_cy;
    logic               w_in_canvas;
    logic [ADDR_W-1:0]  w_paint_addr;

    assign w_accept      = cmd_valid && (r_state == S_IDLE);
    assign w_last_offset = (r_dx == c_brush_last) && (r_dy == c_brush_last);

    // Brush cell relative to the latched centre; negative means off the left/top edge.
    assign w_cx = $signed({2'b00, r_ccx}) + $signed({9'd0, r_dx}) - c_half;
    assign w_cy = $signed({2'b00, r_ccy}) + $signed({9'd0, r_dy}) - c_half;

    assign w_in_canvas = !w_cx[11] && !w_cy[11]
                      && ($unsigned(w_cx) < 12'(CANVAS_W))
                      && ($unsigned(w_cy) < 12'(CANVAS_H));

    assign w_paint_addr = ADDR_W'($unsigned(w_cy)) * ADDR_W'(CANVAS_W)
                        + ADDR_W'($unsigned(w_cx));

    assign pen_x = r_pen_x;
    assign pen_y = r_pen_y;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        cmd_ready    = 1'b0;
        busy         = 1'b1;
        wr_en        = 1'b0;
        wr_addr      = '0;
        wr_color     = 3'd0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    if (cmd_clear) begin
                        w_state_next = S_CLEAR;
                    end else if (cmd_color != 3'd0) begin
                        w_state_next = S_PAINT;
                    end
                end
            end
            S_PAINT: begin
                wr_en    = w_in_canvas;
                wr_addr  = w_in_canvas ? w_paint_addr : '0;
                wr_color = r_color;
                if (w_last_offset) begin
                    w_state_next = S_IDLE;
                end
            end
            S_CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = r_clr_addr;
                if (r_clr_addr == c_last_addr) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                busy         = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ccx      <= '0;
            r_ccy      <= '0;
            r_color    <= '0;
            r_dx       <= '0;
            r_dy       <= '0;
            r_clr_addr <= '0;
            r_pen_x    <= '0;
            r_pen_y    <= '0;
        end else if (w_accept) begin
            r_dx       <= '0;
            r_dy       <= '0;
            r_clr_addr <= '0;
            if (!cmd_clear) begin
                r_pen_x <= cmd_x;
                r_pen_y <= cmd_y;
                r_ccx   <= cmd_x >> SCALE_LOG2;
                r_ccy   <= cmd_y >> SCALE_LOG2;
                r_color <= cmd_color;
            end
        end else if (r_state == S_PAINT) begin
            // Offsets advance dx-fastest and hold at the final offset.
            if (r_dx == c_brush_last) begin
                if (r_dy != c_brush_last) begin
                    r_dx <= '0;
                    r_dy <= r_dy + 3'd1;
                end
            end else begin
                r_dx <= r_dx + 3'd1;
            end
        end else if (r_state == S_CLEAR) begin
            if (r_clr_addr != c_last_addr) begin
                r_clr_addr <= r_clr_addr + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_canvas_painter.sv
// ============================================================================
// Module      : tb_canvas_painter
// Description : Scoreboard bench for canvas_painter with a cell-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_canvas_painter;

    localparam int CW    = 160;
    localparam int CH    = 120;
    localparam int SL    = 2;
    localparam int BR    = 3;
    localparam int AW    = 15;
    localparam int LIMIT = 30000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [9:0]    cmd_x = '0;
    logic [9:0]    cmd_y = '0;
    logic [2:0]    cmd_color = '0;
    logic          cmd_clear = 1'b0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [2:0]    wr_color;
    logic [9:0]    pen_x;
    logic [9:0]    pen_y;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int mdl_pen_x = 0;
    int mdl_pen_y = 0;

    canvas_painter #(
        .CANVAS_W(CW), .CANVAS_H(CH), .SCALE_LOG2(SL), .BRUSH(BR), .ADDR_W(AW)
    ) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_color(cmd_color), .cmd_clear(cmd_clear),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_color(wr_color),
        .pen_x(pen_x), .pen_y(pen_y), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every write the DUT presents must match the next expected {addr,color}.
    always @(negedge clk) begin
        if (!reset && wr_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d color %0d expected none",
                         wr_addr, wr_color);
            end else begin
                int e;
                e = exp_q.pop_front();
                check("write_addr", int'(wr_addr), e / 8);
                check("write_color", int'(wr_color), e % 8);
            end
        end
    end

    // Reference model: stamp a brush square in cell space, keep only cells on the canvas.
    function automatic void model_cmd(input int x, input int y, input int color, input bit clr);
        if (clr) begin
            for (int a = 0; a < CW * CH; a++) exp_q.push_back(a * 8);
        end else begin
            mdl_pen_x = x;
            mdl_pen_y = y;
            if (color != 0) begin
                for (int dy = 0; dy < BR; dy++) begin
                    for (int dx = 0; dx < BR; dx++) begin
                        int cx, cy;
                        cx = x / (1 << SL) + dx - BR / 2;
                        cy = y / (1 << SL) + dy - BR / 2;
                        if (cx >= 0 && cx < CW && cy >= 0 && cy < CH)
                            exp_q.push_back((cy * CW + cx) * 8 + color);
                    end
                end
            end
        end
    endfunction

    task automatic issue(input int x, input int y, input int color, input bit clr);
        @(negedge clk);
        cmd_x     = 10'(x);
        cmd_y     = 10'(y);
        cmd_color = 3'(color);
        cmd_clear = clr;
        cmd_valid = 1'b1;
        model_cmd(x, y, color, clr);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_x     = 10'($urandom);
        cmd_y     = 10'($urandom);
        cmd_color = 3'($urandom);
        cmd_clear = 1'($urandom);
    endtask

    task automatic run_cmd(input int x, input int y, input int color, input bit clr);
        int cycles;
        int exp_cycles;
        exp_cycles = clr ? CW * CH : (color != 0 ? BR * BR : 0);
        issue(x, y, color, clr);
        cycles = 0;
        while (!cmd_ready && cycles < LIMIT) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check("busy_cycles", cycles, exp_cycles);
        check("busy_after", int'(busy), 0);
        @(negedge clk);
        check("pending_writes", exp_q.size(), 0);
        exp_q.delete();
        check("pen_x", int'(pen_x), mdl_pen_x);
        check("pen_y", int'(pen_y), mdl_pen_y);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("rst_ready", int'(cmd_ready), 1);
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_wr_addr", int'(wr_addr), 0);
        check("rst_wr_color", int'(wr_color), 0);
        check("rst_pen_x", int'(pen_x), 0);
        check("rst_pen_y", int'(pen_y), 0);
        check("rst_busy", int'(busy), 0);

        run_cmd(320, 240, 3, 1'b0);
        run_cmd(0, 0, 1, 1'b0);
        run_cmd(100, 50, 0, 1'b0);
        run_cmd(639, 479, 5, 1'b0);
        run_cmd(1023, 1023, 7, 1'b0);
        run_cmd(4, 479, 2, 1'b0);
        run_cmd(0, 0, 6, 1'b1);

        for (int i = 0; i < 40; i++) begin
            int x, y, c;
            case ($urandom_range(0, 3))
                0:       x = $urandom_range(0, 7);
                1:       x = $urandom_range(632, 647);
                default: x = $urandom_range(0, 1023);
            endcase
            y = ($urandom_range(0, 2) == 0) ? $urandom_range(470, 490) : $urandom_range(0, 1023);
            c = $urandom_range(0, 7);
            run_cmd(x, y, c, 1'b0);
        end

        // Abort a clear five cycles in.
        issue(0, 0, 0, 1'b1);
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("abort_wr_en", int'(wr_en), 0);
        exp_q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        mdl_pen_x = 0;
        mdl_pen_y = 0;
        @(negedge clk);
        check("abort_ready", int'(cmd_ready), 1);
        check("abort_busy", int'(busy), 0);
        check("abort_pen_x", int'(pen_x), 0);
        run_cmd(320, 240, 3, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
